// File: rtl/mem_port_pkg.sv
// mem_port_pkg
//   Shared definitions for the memory-port responder slice:
//   - rw_t    : request codes carried on RW
//   - state_t : responder FSM states (CLEAR is only reachable when
//               MEM_INIT_CLEAR_EN is defined)
//   - CNT_W   : width of the access-latency counter (WAIT_CYCLES 0..15)
package mem_port_pkg;

    typedef enum logic [1:0] {
        RW_IDLE    = 2'b00,
        RW_WRITE   = 2'b01,
        RW_READ    = 2'b10,
        RW_ILLEGAL = 2'b11
    } rw_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10,
        CLEAR  = 2'b11
    } state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_array.sv
// mem_port_array
//   Single-port synchronous storage array, 2^DEPTH_LOG2 entries of WIDTH bits.
//   Write and read share one address; read data is registered and holds its
//   value until the next read enable. Contents are not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable (wdata -> mem[addr])
//   re     in  read enable  (mem[addr] -> rdata on the next edge)
//   addr   in  DEPTH_LOG2-bit entry index
//   wdata  in  WIDTH-bit write data
//   rdata  out WIDTH-bit registered read data
module mem_port_array #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder
//   Target-side end of the A/RW/W1/W2/R1/R2/Ack memory-port protocol.
//   A request (RW != 00) is latched in IDLE, the access is performed after
//   WAIT_CYCLES+1 clocks, and Ack is held high in RESP until RW returns to 00.
//   Build option: MEM_INIT_CLEAR_EN -- after reset, sweep the whole array to
//   zero (one entry per clock) before accepting requests.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  synchronous active-high reset
//   A         in  request address (only A[DEPTH_LOG2-1:0] indexes the array)
//   RW        in  request code: 00 idle, 01 write, 10 read, 11 illegal
//   W1, W2    in  write data lanes 0/1
//   WdataAck  out per-lane write acknowledge (bit0 = W1, bit1 = W2)
//   R1, R2    out read data lanes 0/1, valid and stable throughout RESP
//   RDataAck  in  initiator's per-lane read-data acknowledge
//   Ack       out transaction acknowledge
//   err       out sticky error flag (out of range, illegal code, unacked read)
//   VDD, VSS  in  supply pins, no logic function
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [1:0]        RW,
    input  logic [DATA_W-1:0] W1,
    input  logic [DATA_W-1:0] W2,
    output logic [1:0]        WdataAck,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    input  logic [1:0]        RDataAck,
    output logic              Ack,
    output logic              err,
    input  logic              VDD,
    input  logic              VSS
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   lat_addr;
    rw_t                 lat_rw;
    logic [DATA_W-1:0]   lat_w1, lat_w2;
    logic [CNT_W-1:0]    cnt;
    logic                err_q;
    logic                rdack_seen;
    logic                in_range;
    logic                access_now;

    logic                    arr_we, arr_re;
    logic [DEPTH_LOG2-1:0]   arr_addr;
    logic [2*DATA_W-1:0]     arr_wdata, arr_rdata;

    logic                unused_supply;
    assign unused_supply = VDD ^ VSS;

`ifdef MEM_INIT_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [DEPTH_LOG2-1:0] clr_idx;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    assign in_range   = (lat_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign access_now = (state == ACCESS) && (cnt == '0);
    assign err        = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (RW != RW_IDLE) state_nx = ACCESS;
            ACCESS:  if (cnt == '0)     state_nx = RESP;
            RESP:    if (RW == RW_IDLE) state_nx = IDLE;
`ifdef MEM_INIT_CLEAR_EN
            CLEAR:   if (clr_idx == '1) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, latency counter, error tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            err_q      <= 1'b0;
            rdack_seen <= 1'b0;
`ifdef MEM_INIT_CLEAR_EN
            clr_idx    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (RW != RW_IDLE) begin
                        lat_addr <= A;
                        lat_rw   <= rw_t'(RW);
                        lat_w1   <= W1;
                        lat_w2   <= W2;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdack_seen <= 1'b0;
                        if (lat_rw == RW_ILLEGAL || !in_range) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (RDataAck == 2'b11) begin
                        rdack_seen <= 1'b1;
                    end
                    // The exit edge itself counts as a sampling opportunity.
                    if (RW == RW_IDLE && lat_rw == RW_READ &&
                        !rdack_seen && RDataAck != 2'b11) begin
                        err_q <= 1'b1;
                    end
                end
`ifdef MEM_INIT_CLEAR_EN
                CLEAR: clr_idx <= clr_idx + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Outputs and array control
    always_comb begin
        Ack       = 1'b0;
        WdataAck  = '0;
        R1        = '0;
        R2        = '0;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = lat_addr[DEPTH_LOG2-1:0];
        arr_wdata = {lat_w2, lat_w1};

        // Gating with rst keeps an access coinciding with reset uncommitted.
        if (!rst && access_now && in_range) begin
            arr_we = (lat_rw == RW_WRITE);
            arr_re = (lat_rw == RW_READ);
        end
`ifdef MEM_INIT_CLEAR_EN
        if (!rst && state == CLEAR) begin
            arr_we    = 1'b1;
            arr_addr  = clr_idx;
            arr_wdata = '0;
        end
`endif

        if (state == RESP) begin
            Ack = 1'b1;
            if (lat_rw == RW_WRITE) begin
                WdataAck = 2'b11;
            end
            // Out-of-range reads never load the array, so force zero data.
            if (lat_rw == RW_READ && in_range) begin
                R1 = arr_rdata[DATA_W-1:0];
                R2 = arr_rdata[2*DATA_W-1:DATA_W];
            end
        end
    end

    mem_port_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (2*DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_port_responder.sv
// tb_mem_port_responder
//   Directed scoreboard bench for mem_port_responder. The stimulus side pushes
//   the expected response for every request; a monitor pops and compares on
//   each rising edge of Ack. Expectations depend on MEM_INIT_CLEAR_EN, since
//   with it every reset wipes the array to zero.
module tb_mem_port_responder;

    localparam int unsigned WAIT = 2;
`ifdef MEM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic [1:0] wd;
        logic [3:0] r1;
        logic [3:0] r2;
        logic       err;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] A = '0;
    logic [1:0]  RW = '0;
    logic [3:0]  W1 = '0, W2 = '0;
    logic [1:0]  WdataAck;
    logic [3:0]  R1, R2;
    logic [1:0]  RDataAck = '0;
    logic        Ack, err;
    logic        VDD = 1'b1, VSS = 1'b0;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sb[$];
    logic        ack_prev = 1'b0;

    mem_port_responder #(
        .ADDR_W      (17),
        .DATA_W      (4),
        .DEPTH_LOG2  (8),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .RW       (RW),
        .W1       (W1),
        .W2       (W2),
        .WdataAck (WdataAck),
        .R1       (R1),
        .R2       (R2),
        .RDataAck (RDataAck),
        .Ack      (Ack),
        .err      (err),
        .VDD      (VDD),
        .VSS      (VSS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every rising Ack must match the oldest expected response.
    always @(negedge clk) begin
        if (Ack === 1'b1 && ack_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got Ack=1 expected no response (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_wdack"}, WdataAck, e.wd);
                chk({e.name, "_r1"}, R1, e.r1);
                chk({e.name, "_r2"}, R2, e.r2);
                chk({e.name, "_err"}, err, e.err);
            end
        end
        ack_prev = Ack;
    end

    // One complete transaction: request, wait for Ack, hold, drop RW, check exit.
    task automatic txn(input string name, input logic [16:0] a, input logic [1:0] rw,
                       input logic [3:0] w1, input logic [3:0] w2, input logic [1:0] rdack,
                       input logic [1:0] exp_wd, input logic [3:0] er1, input logic [3:0] er2,
                       input logic err_ack, input logic err_exit);
        exp_t e;
        int unsigned lat;
        e.wd = exp_wd; e.r1 = er1; e.r2 = er2; e.err = err_ack; e.name = name;
        @(negedge clk);
        sb.push_back(e);
        A = a; RW = rw; W1 = w1; W2 = w2; RDataAck = rdack;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Inputs other than RW must not be re-sampled after the latch.
                A = ~a; W1 = ~w1; W2 = ~w2;
            end
            if (Ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, lat, WAIT + 2);
        @(negedge clk);
        chk({name, "_ack_hold"}, Ack, 1'b1);
        chk({name, "_r1_hold"}, R1, er1);
        RW = 2'b00;
        @(negedge clk);
        chk({name, "_exit_ack"}, Ack, 1'b0);
        chk({name, "_exit_wdack"}, WdataAck, 2'b00);
        chk({name, "_exit_r"}, {R2, R1}, 8'h00);
        chk({name, "_exit_err"}, err, err_exit);
        RDataAck = 2'b00; A = '0; W1 = '0; W2 = '0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; RW = 2'b00; RDataAck = 2'b00;
        repeat (2) @(negedge clk);
        chk({name, "_ack"}, Ack, 1'b0);
        chk({name, "_wdack"}, WdataAck, 2'b00);
        chk({name, "_r"}, {R2, R1}, 8'h00);
        chk({name, "_err"}, err, 1'b0);
        rst = 1'b0;
        if (CLR) repeat (256) @(negedge clk);
    endtask

    initial begin
        int unsigned hi;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("reset_ack", Ack, 1'b0);
        chk("reset_wdack", WdataAck, 2'b00);
        chk("reset_r", {R2, R1}, 8'h00);
        chk("reset_err", err, 1'b0);
`ifdef MEM_INIT_CLEAR_EN
        // Read of 0xFF held through the sweep; served only once CLEAR ends.
        e.wd = 2'b00; e.r1 = 4'h0; e.r2 = 4'h0; e.err = 1'b0; e.name = "clear_read";
        sb.push_back(e);
        A = 17'h000FF; RW = 2'b10; RDataAck = 2'b11;
        rst = 1'b0;
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (Ack === 1'b1) hi++;
        end
        chk("clear_ack_low", hi, 0);
        hi = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (Ack === 1'b1) begin
                hi = 1;
                break;
            end
        end
        chk("clear_read_ack", hi, 1);
        RW = 2'b00;
        @(negedge clk);
        RDataAck = 2'b00;
        chk("clear_read_exit", Ack, 1'b0);
`else
        rst = 1'b0;
`endif

        //   name         addr        rw     w1    w2    rdack  wd     r1    r2    errA  errX
        txn("wr5",   17'h00005, 2'b01, 4'h1, 4'h2, 2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        txn("rd5",   17'h00005, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00, 4'h1, 4'h2, 1'b0, 1'b0);
        txn("wr7",   17'h00007, 2'b01, 4'hA, 4'hB, 2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        txn("wr11",  17'h00011, 2'b01, 4'h3, 4'h4, 2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        txn("wrFF",  17'h000FF, 2'b01, 4'hF, 4'hE, 2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        txn("wr0",   17'h00000, 2'b01, 4'h6, 4'h9, 2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0);
        txn("rdFF",  17'h000FF, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00, 4'hF, 4'hE, 1'b0, 1'b0);
        txn("rd0",   17'h00000, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00, 4'h6, 4'h9, 1'b0, 1'b0);
        txn("rd7",   17'h00007, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00, 4'hA, 4'hB, 1'b0, 1'b0);
        txn("rd11",  17'h00011, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00, 4'h3, 4'h4, 1'b0, 1'b0);

        // Reset while a write to 0x07 is still in ACCESS.
        @(negedge clk);
        A = 17'h00007; RW = 2'b01; W1 = 4'h5; W2 = 4'h5;
        repeat (2) @(negedge clk);
        rst = 1'b1; RW = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ack", Ack, 1'b0);
        chk("midrst_wdack", WdataAck, 2'b00);
        chk("midrst_r", {R2, R1}, 8'h00);
        chk("midrst_err", err, 1'b0);
        hi = 0;
        repeat (CLR ? 260 : 8) begin
            @(negedge clk);
            if (Ack === 1'b1) hi++;
        end
        chk("midrst_no_ack", hi, 0);
        txn("rd7_after_rst", 17'h00007, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00,
            CLR ? 4'h0 : 4'hA, CLR ? 4'h0 : 4'hB, 1'b0, 1'b0);

        txn("illegal", 17'h00005, 2'b11, 4'h9, 4'h9, 2'b00, 2'b00, 4'h0, 4'h0, 1'b1, 1'b1);
        txn("rd5_after_ill", 17'h00005, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00,
            CLR ? 4'h0 : 4'h1, CLR ? 4'h0 : 4'h2, 1'b1, 1'b1);

        do_reset("rst2");
        txn("oor_wr", 17'h11111, 2'b01, 4'h1, 4'h1, 2'b00, 2'b11, 4'h0, 4'h0, 1'b1, 1'b1);
        txn("rd11_after_oor", 17'h00011, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00,
            CLR ? 4'h0 : 4'h3, CLR ? 4'h0 : 4'h4, 1'b1, 1'b1);

        do_reset("rst3");
        txn("rd5_noack", 17'h00005, 2'b10, 4'h0, 4'h0, 2'b00, 2'b00,
            CLR ? 4'h0 : 4'h1, CLR ? 4'h0 : 4'h2, 1'b0, 1'b1);
        txn("rdFF_sticky", 17'h000FF, 2'b10, 4'h0, 4'h0, 2'b11, 2'b00,
            CLR ? 4'h0 : 4'hF, CLR ? 4'h0 : 4'hE, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Target-side (responder) end of the A/RW/W1/W2/R1/R2/Ack memory-port protocol.
- Accepts write and read requests from an initiator, stores two 4-bit data lanes per address in an internal array, and returns read data.
- Completes each transaction with a four-phase Ack handshake, plus per-lane write acknowledge and read-data acknowledge.
- Used as the behavioural memory model behind the 16nm write/read testbenches and as synthesizable reference RTL.

Parameters:
- ADDR_W, 17: width of the A address bus.
- DATA_W, 4: width of each data lane (W1/W2/R1/R2).
- DEPTH_LOG2, 8: log2 of the number of array entries. Only A[DEPTH_LOG2-1:0] indexes the array.
- WAIT_CYCLES, 2: emulated access latency in clocks. Legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- A  in  ADDR_W  request address.
- RW  in  2  request code: 00 idle, 01 write, 10 read, 11 illegal.
- W1  in  DATA_W  write data, lane 0.
- W2  in  DATA_W  write data, lane 1.
- WdataAck  out  2  per-lane write acknowledge. Bit0 is W1, bit1 is W2.
- R1  out  DATA_W  read data, lane 0.
- R2  out  DATA_W  read data, lane 1.
- RDataAck  in  2  initiator's per-lane read-data acknowledge.
- Ack  out  1  transaction acknowledge.
- err  out  1  sticky error flag. Cleared only by rst.
- VDD  in  1  supply pin. No logic function.
- VSS  in  1  supply pin. No logic function.

Behaviour:
- Reset (synchronous, active-high):
  - Ack, WdataAck, R1, R2 and err all go to 0. State goes to IDLE.
  - Array contents are not reset, except as described under Optional Feature.
- States: IDLE, ACCESS, RESP (plus CLEAR when the optional feature is enabled).
- IDLE:
  - Ack=0.
  - On an edge where RW!=00: latch A, RW, W1 and W2; load the wait counter with WAIT_CYCLES; go to ACCESS.
  - Inputs are not re-sampled after the latch until the next IDLE.
- ACCESS:
  - The counter decrements each cycle. When it reaches 0 (after one cycle if WAIT_CYCLES=0), the access is performed and the state goes to RESP.
  - Latency: if RW is sampled at edge N, Ack is high after edge N+WAIT_CYCLES+1.
- Out of range: a latched address with A[ADDR_W-1:DEPTH_LOG2]!=0 sets err. Write is suppressed; read returns 0.
- Write (01): {W2,W1} is stored at the index. In RESP, WdataAck=11 and Ack=1.
- Read (10): R1/R2 are loaded from the array and held stable for the whole of RESP. Ack=1 and WdataAck=00.
- Illegal (11): no array access. err is set; the state goes to RESP with Ack=1 and WdataAck=00.
- RESP exit:
  - Ack stays 1 until RW==00 is sampled. On that edge: Ack=0, WdataAck=00, R1=R2=0, state goes to IDLE.
  - Read without acknowledge: if RDataAck==11 was never sampled during RESP, err is set at exit.
  - RDataAck has no effect outside RESP.
- Back-to-back: a new request is accepted no earlier than the edge after the return to IDLE (at least one Ack-low cycle).
- Reset mid-operation: the transaction is abandoned. A write still in ACCESS is not committed; writes already committed remain.

Optional Feature:
- MEM_INIT_CLEAR_EN defined:
  - After rst deasserts, the block enters CLEAR and writes 0 to all 2^DEPTH_LOG2 entries, one per cycle, then goes to IDLE.
  - Requests are ignored and Ack stays 0 during CLEAR.
  - Asserting rst during CLEAR restarts the sweep.
- MEM_INIT_CLEAR_EN undefined: no CLEAR state. IDLE is entered directly after reset; array contents are uninitialized (X in simulation).

Decomposition:
- mem_port_pkg holds:
  - RW encodings: RW_IDLE=2'b00, RW_WRITE=2'b01, RW_READ=2'b10, RW_ILLEGAL=2'b11.
  - The state enum: IDLE/ACCESS/RESP/CLEAR.
  - The WAIT_CYCLES counter width constant.
- Sub-module mem_port_array: single-port synchronous array, 2^DEPTH_LOG2 x 2*DATA_W, with write enable and registered read. The FSM stays in mem_port_responder.

Test Plan:
- Write then read back:
  - A=17'h00005, RW=01, W1=4'h1, W2=4'h2 -> Ack high 3 cycles after sampling (WAIT_CYCLES=2), WdataAck=11. Drop RW -> Ack=0 next edge.
  - Read at 17'h00005 with RDataAck=11 -> R1=1, R2=2, err=0.
- Out-of-range write: A=17'h11111, RW=01, W1=W2=4'h1 -> Ack=1, WdataAck=11, err=1. Read of 17'h00011 does not return 1/1.
- Illegal code: RW=11 -> Ack=1, WdataAck=00, err=1, no array change.
- Read without acknowledge: read with RDataAck held 00, RW then dropped -> Ack falls, err=1.
- Reset mid-ACCESS: write to 17'h00007 with rst pulsed during ACCESS -> Ack never rises, all outputs 0. A later read of 0x07 returns the prior contents (0 with MEM_INIT_CLEAR_EN).
- MEM_INIT_CLEAR_EN: request issued during CLEAR -> Ack stays 0 for 256 cycles. After CLEAR, a read of 0xFF returns R1=R2=0.
